// File: rtl/video_fetch.sv
`default_nettype none
// ============================================================================
// Module   : video_fetch
// Purpose  : Frame-buffer prefetch engine. Issues aligned 4-word SDRAM burst
//            reads, one per 8 MHz chipset slot, buffers the returned 64-bit
//            lines in a small FIFO and presents them to the video shifter one
//            16-bit word at a time.
// Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
// Parameters:
//   DEPTH         FIFO depth in 64-bit lines (power of two, 2..8)
//   CAPTURE_PHASE clk_128 cycles after a slot strobe at which ram_dout holds
//                 the completed burst (1..15)
// Ports:
//   clk_128     in   1   system clock, 128 MHz
//   reset       in   1   asynchronous active-high reset
//   clk_8_en    in   1   slot strobe, one cycle in sixteen
//   load        in   1   restart fetch at start_addr and flush the FIFO
//   start_addr  in  24   word address of frame start ([1:0] ignored)
//   end_addr    in  24   circular frame end (only with VIDEO_FETCH_WRAP_EN)
//   fetch_en    in   1   video may use the next slot
//   ram_oe      out  1   read request, held for a full slot
//   ram_addr    out 24   burst word address, [1:0] always 0
//   ram_dout    in  64   burst data, word n in [16n+15:16n]
//   word_rd     in   1   shifter consumes the presented word
//   word        out 16   current word
//   word_valid  out  1   FIFO non-empty
//   underrun    out  1   sticky read-while-empty flag, cleared by load
//   level       out  6   words held in the FIFO
// Configuration macro:
//   VIDEO_FETCH_WRAP_EN  adds end_addr; fetch_addr reloads start_addr when an
//                        advance would reach the aligned end_addr.
// ============================================================================
module video_fetch #(
    parameter int DEPTH         = 4,
    parameter int CAPTURE_PHASE = 8
) (
    input  logic        clk_128,
    input  logic        reset,
    input  logic        clk_8_en,
    input  logic        load,
    input  logic [23:0] start_addr,
`ifdef VIDEO_FETCH_WRAP_EN
    input  logic [23:0] end_addr,
`endif
    input  logic        fetch_en,
    output logic        ram_oe,
    output logic [23:0] ram_addr,
    input  logic [63:0] ram_dout,
    input  logic        word_rd,
    output logic [15:0] word,
    output logic        word_valid,
    output logic        underrun,
    output logic [5:0]  level
);

    localparam int c_PTR_W = $clog2(DEPTH);
    localparam int c_CNT_W = $clog2(DEPTH + 1);

    localparam logic [c_CNT_W-1:0] c_DEPTH = c_CNT_W'(DEPTH);
    localparam logic [3:0]         c_CAP   = 4'(CAPTURE_PHASE);

    localparam logic [1:0] c_ST_IDLE = 2'd0;
    localparam logic [1:0] c_ST_REQ  = 2'd1;
    localparam logic [1:0] c_ST_WAIT = 2'd2;

    logic [1:0]         r_state;
    logic [3:0]         r_phase;
    logic               r_discard;
    logic [23:0]        r_fetch_addr;
    logic               r_ram_oe;
    logic [23:0]        r_ram_addr;
    logic [63:0]        r_mem [DEPTH];
    logic [c_PTR_W-1:0] r_wr_ptr;
    logic [c_PTR_W-1:0] r_rd_ptr;
    logic [c_CNT_W-1:0] r_count;
    logic [1:0]         r_sel;
    logic [15:0]        r_word;
    logic               r_underrun;

    logic [23:0]        w_start_line;
    logic               w_has_data;
    logic               w_rd_ok;
    logic               w_pop;
    logic               w_cap;
    logic               w_issue;
    logic [23:0]        w_adv;
    logic [23:0]        w_next_fetch;
    logic [c_CNT_W-1:0] w_count_after_pop;
    logic [c_CNT_W-1:0] w_count_next;
    logic [c_PTR_W-1:0] w_rd_ptr_next;
    logic [1:0]         w_sel_next;
    logic [63:0]        w_head_line;
    logic [15:0]        w_word_next;
    logic               w_unused_bits;

    assign w_start_line = {start_addr[23:2], 2'b00};
    assign w_has_data   = (r_count != '0);

    // load wins over a same-cycle read or capture.
    assign w_rd_ok = word_rd && w_has_data && !load;
    assign w_pop   = w_rd_ok && (r_sel == 2'd3);
    assign w_cap   = (r_state == c_ST_REQ) && (r_phase == c_CAP) && !r_discard && !load;

    // No line is in flight at a strobe (capture always precedes the next
    // strobe), so the stored count alone decides whether space remains.
    // A load flushes the FIFO on the same edge, so space is then guaranteed.
    assign w_issue = clk_8_en && (r_state != c_ST_REQ) && fetch_en &&
                     (load || (r_count < c_DEPTH));

    assign w_adv = r_fetch_addr + 24'd4;

`ifdef VIDEO_FETCH_WRAP_EN
    assign w_next_fetch  = (w_adv == {end_addr[23:2], 2'b00}) ? w_start_line : w_adv;
    assign w_unused_bits = &{1'b0, start_addr[1:0], end_addr[1:0]};
`else
    assign w_next_fetch  = w_adv;
    assign w_unused_bits = &{1'b0, start_addr[1:0]};
`endif

    assign w_count_after_pop = r_count - c_CNT_W'(w_pop);
    assign w_count_next      = load ? '0 : (w_count_after_pop + c_CNT_W'(w_cap));
    assign w_rd_ptr_next     = load ? '0 : (r_rd_ptr + c_PTR_W'(w_pop));
    assign w_sel_next        = load ? 2'd0 : (r_sel + 2'(w_rd_ok));

    // When the line being captured becomes the head on this very edge, the
    // memory does not hold it yet, so the word register is fed from ram_dout.
    assign w_head_line = (w_cap && (w_count_after_pop == '0)) ? ram_dout
                                                              : r_mem[w_rd_ptr_next];
    assign w_word_next = (w_count_next == '0) ? 16'd0
                                              : w_head_line[16*w_sel_next +: 16];

    always_ff @(posedge clk_128) begin
        if (w_cap) begin
            r_mem[r_wr_ptr] <= ram_dout;
        end
    end

    always_ff @(posedge clk_128 or posedge reset) begin
        if (reset) begin
            r_state      <= c_ST_IDLE;
            r_phase      <= 4'd0;
            r_discard    <= 1'b0;
            r_fetch_addr <= 24'd0;
            r_ram_oe     <= 1'b0;
            r_ram_addr   <= 24'd0;
            r_wr_ptr     <= '0;
            r_rd_ptr     <= '0;
            r_count      <= '0;
            r_sel        <= 2'd0;
            r_word       <= 16'd0;
            r_underrun   <= 1'b0;
        end else begin
            // Phase k means k cycles have elapsed since the slot strobe.
            r_phase <= clk_8_en ? 4'd1 : (r_phase + 4'd1);

            case (r_state)
                c_ST_IDLE, c_ST_WAIT: begin
                    if (clk_8_en) begin
                        if (w_issue) begin
                            r_state    <= c_ST_REQ;
                            r_ram_oe   <= 1'b1;
                            r_ram_addr <= load ? w_start_line : r_fetch_addr;
                        end else begin
                            r_state  <= c_ST_IDLE;
                            r_ram_oe <= 1'b0;
                        end
                    end
                end
                c_ST_REQ: begin
                    // ram_oe stays high into WAIT so the slot is never cut short.
                    if (r_phase == c_CAP) begin
                        r_state <= c_ST_WAIT;
                    end
                end
                default: begin
                    r_state  <= c_ST_IDLE;
                    r_ram_oe <= 1'b0;
                end
            endcase

            // A load during an outstanding burst marks its data as stale.
            if (w_issue) begin
                r_discard <= 1'b0;
            end else if (load) begin
                r_discard <= 1'b1;
            end else if ((r_state == c_ST_REQ) && (r_phase == c_CAP)) begin
                r_discard <= 1'b0;
            end

            if (load) begin
                r_fetch_addr <= w_start_line;
            end else if (w_cap) begin
                r_fetch_addr <= w_next_fetch;
            end

            r_wr_ptr <= load ? '0 : (r_wr_ptr + c_PTR_W'(w_cap));
            r_rd_ptr <= w_rd_ptr_next;
            r_count  <= w_count_next;
            r_sel    <= w_sel_next;
            r_word   <= w_word_next;

            if (load) begin
                r_underrun <= 1'b0;
            end else if (word_rd && !w_has_data) begin
                r_underrun <= 1'b1;
            end
        end
    end

    assign ram_oe     = r_ram_oe;
    assign ram_addr   = r_ram_addr;
    assign word       = r_word;
    assign word_valid = w_has_data;
    assign underrun   = r_underrun;
    assign level      = 6'({r_count, 2'b00}) - 6'(r_sel);

endmodule
`default_nettype wire

// File: tb/tb_video_fetch.sv
`default_nettype none
// ============================================================================
// Module   : tb_video_fetch
// Purpose  : Directed self-checking bench for video_fetch. A single thread
//            advances the clock one edge at a time, generates the slot strobe
//            and tracks the slot phase of the upcoming edge in tb_phase.
// Revision : 1.0 - initial release
// ============================================================================
module tb_video_fetch;

    logic        clk_128;
    logic        reset;
    logic        clk_8_en;
    logic        load;
    logic [23:0] start_addr;
`ifdef VIDEO_FETCH_WRAP_EN
    logic [23:0] end_addr;
`endif
    logic        fetch_en;
    logic        ram_oe;
    logic [23:0] ram_addr;
    logic [63:0] ram_dout;
    logic        word_rd;
    logic [15:0] word;
    logic        word_valid;
    logic        underrun;
    logic [5:0]  level;

    int total = 0;
    int bad   = 0;
    int tb_phase = 15;

    video_fetch #(.DEPTH(4), .CAPTURE_PHASE(8)) dut (
        .clk_128    (clk_128),
        .reset      (reset),
        .clk_8_en   (clk_8_en),
        .load       (load),
        .start_addr (start_addr),
`ifdef VIDEO_FETCH_WRAP_EN
        .end_addr   (end_addr),
`endif
        .fetch_en   (fetch_en),
        .ram_oe     (ram_oe),
        .ram_addr   (ram_addr),
        .ram_dout   (ram_dout),
        .word_rd    (word_rd),
        .word       (word),
        .word_valid (word_valid),
        .underrun   (underrun),
        .level      (level)
    );

    initial begin
        clk_128 = 1'b0;
        forever #5 clk_128 = ~clk_128;
    end

    // Advance past one rising edge; afterwards tb_phase is the slot phase of
    // the next edge (0 = strobe edge).
    task automatic tick();
        @(posedge clk_128);
        #1;
        tb_phase = (tb_phase + 1) % 16;
        clk_8_en = (tb_phase == 0);
    endtask

    task automatic run_to_phase(input int k);
        int n;
        n = 0;
        while (tb_phase != k && n < 40) begin
            tick();
            n++;
        end
        total++;
        if (tb_phase != k) begin
            bad++;
            $display("FAIL phase_sync: got %0d want %0d", tb_phase, k);
        end
    endtask

    task automatic test_reset();
        reset = 1'b1; load = 1'b0; fetch_en = 1'b0; word_rd = 1'b0;
        start_addr = 24'd0; ram_dout = 64'd0; clk_8_en = 1'b0;
`ifdef VIDEO_FETCH_WRAP_EN
        end_addr = 24'd0;
`endif
        tick();
        tick();
        total++;
        if (ram_oe !== 1'b0 || ram_addr !== 24'd0) begin
            bad++;
            $display("FAIL reset_req: got oe=%b addr=%h want oe=0 addr=000000", ram_oe, ram_addr);
        end
        total++;
        if (word !== 16'd0 || word_valid !== 1'b0) begin
            bad++;
            $display("FAIL reset_word: got word=%h valid=%b want 0000/0", word, word_valid);
        end
        total++;
        if (underrun !== 1'b0 || level !== 6'd0) begin
            bad++;
            $display("FAIL reset_flags: got underrun=%b level=%0d want 0/0", underrun, level);
        end
        reset = 1'b0;
        tick();
    endtask

    task automatic test_fill();
        logic [23:0] exp_addr;
        logic        oe_gap;
        logic        oe_seen;
        start_addr = 24'h001000;
        fetch_en   = 1'b1;
        ram_dout   = 64'd0;
        load = 1'b1;
        tick();
        load = 1'b0;
        run_to_phase(0);
        oe_gap = 1'b0;
        for (int i = 0; i < 4; i++) begin
            tick();
            exp_addr = 24'h001000 + 24'(4 * i);
            total++;
            if (ram_oe !== 1'b1 || ram_addr !== exp_addr) begin
                bad++;
                $display("FAIL fill_slot%0d: got oe=%b addr=%h want oe=1 addr=%h",
                         i, ram_oe, ram_addr, exp_addr);
            end
            for (int j = 1; j < 16; j++) begin
                tick();
                if (ram_oe !== 1'b1) oe_gap = 1'b1;
            end
        end
        total++;
        if (oe_gap !== 1'b0) begin
            bad++;
            $display("FAIL fill_oe_continuous: got gap=%b want 0", oe_gap);
        end
        tick();  // fifth strobe
        total++;
        if (ram_oe !== 1'b0) begin
            bad++;
            $display("FAIL fill_fifth_strobe: got oe=%b want 0", ram_oe);
        end
        total++;
        if (level !== 6'd16) begin
            bad++;
            $display("FAIL fill_level: got %0d want 16", level);
        end
        oe_seen = 1'b0;
        for (int j = 0; j < 16; j++) begin
            tick();
            if (ram_oe !== 1'b0) oe_seen = 1'b1;
        end
        total++;
        if (oe_seen !== 1'b0) begin
            bad++;
            $display("FAIL fill_no_issue: got oe_seen=%b want 0", oe_seen);
        end
    endtask

    task automatic test_stream();
        logic [15:0] exp_w [4];
        exp_w[0] = 16'h1111; exp_w[1] = 16'h2222; exp_w[2] = 16'h3333; exp_w[3] = 16'h4444;
        fetch_en   = 1'b0;
        start_addr = 24'h003000;
        load = 1'b1;
        tick();
        load = 1'b0;
        total++;
        if (level !== 6'd0 || word_valid !== 1'b0) begin
            bad++;
            $display("FAIL stream_flush: got level=%0d valid=%b want 0/0", level, word_valid);
        end
        run_to_phase(0);
        fetch_en = 1'b1;
        ram_dout = 64'h4444_3333_2222_1111;
        tick();
        fetch_en = 1'b0;
        total++;
        if (ram_addr !== 24'h003000) begin
            bad++;
            $display("FAIL stream_addr: got %h want 003000", ram_addr);
        end
        run_to_phase(9);
        word_rd = 1'b1;
        for (int i = 0; i < 4; i++) begin
            total++;
            if (word !== exp_w[i] || level !== 6'(4 - i) || word_valid !== 1'b1) begin
                bad++;
                $display("FAIL stream_word%0d: got word=%h level=%0d valid=%b want %h/%0d/1",
                         i, word, level, word_valid, exp_w[i], 4 - i);
            end
            tick();
        end
        word_rd = 1'b0;
        total++;
        if (level !== 6'd0 || word_valid !== 1'b0 || underrun !== 1'b0) begin
            bad++;
            $display("FAIL stream_drained: got level=%0d valid=%b underrun=%b want 0/0/0",
                     level, word_valid, underrun);
        end
    endtask

    task automatic test_underrun();
        word_rd = 1'b1;
        tick();
        word_rd = 1'b0;
        total++;
        if (underrun !== 1'b1) begin
            bad++;
            $display("FAIL underrun_set: got %b want 1", underrun);
        end
        repeat (5) tick();
        total++;
        if (underrun !== 1'b1) begin
            bad++;
            $display("FAIL underrun_sticky: got %b want 1", underrun);
        end
        start_addr = 24'h002000;
        load = 1'b1;
        tick();
        load = 1'b0;
        total++;
        if (underrun !== 1'b0) begin
            bad++;
            $display("FAIL underrun_clear: got %b want 0", underrun);
        end
    endtask

    task automatic test_load_discard();
        fetch_en = 1'b1;
        run_to_phase(0);
        ram_dout = 64'hDEAD_BEEF_CAFE_F00D;
        tick();
        total++;
        if (ram_addr !== 24'h002000 || ram_oe !== 1'b1) begin
            bad++;
            $display("FAIL discard_issue: got oe=%b addr=%h want 1/002000", ram_oe, ram_addr);
        end
        start_addr = 24'h008000;
        run_to_phase(3);
        load = 1'b1;
        tick();
        load = 1'b0;
        run_to_phase(10);
        total++;
        if (level !== 6'd0 || word_valid !== 1'b0) begin
            bad++;
            $display("FAIL discard_dropped: got level=%0d valid=%b want 0/0", level, word_valid);
        end
        total++;
        if (ram_oe !== 1'b1) begin
            bad++;
            $display("FAIL discard_slot_complete: got oe=%b want 1", ram_oe);
        end
        run_to_phase(0);
        ram_dout = 64'hDDDD_CCCC_BBBB_AAAA;
        tick();
        total++;
        if (ram_addr !== 24'h008000) begin
            bad++;
            $display("FAIL discard_next_addr: got %h want 008000", ram_addr);
        end
    endtask

    task automatic test_back_to_back();
        run_to_phase(9);
        total++;
        if (level !== 6'd4 || word !== 16'hAAAA) begin
            bad++;
            $display("FAIL b2b_lineA: got level=%0d word=%h want 4/aaaa", level, word);
        end
        word_rd = 1'b1;
        repeat (3) tick();
        word_rd = 1'b0;
        total++;
        if (level !== 6'd1 || word !== 16'hDDDD) begin
            bad++;
            $display("FAIL b2b_last_word: got level=%0d word=%h want 1/dddd", level, word);
        end
        ram_dout = 64'h8888_7777_6666_5555;
        run_to_phase(0);
        tick();
        fetch_en = 1'b0;
        total++;
        if (ram_addr !== 24'h008004) begin
            bad++;
            $display("FAIL b2b_addr: got %h want 008004", ram_addr);
        end
        run_to_phase(8);
        word_rd = 1'b1;
        tick();
        word_rd = 1'b0;
        total++;
        if (level !== 6'd4 || word !== 16'h5555 || word_valid !== 1'b1) begin
            bad++;
            $display("FAIL b2b_coincide: got level=%0d word=%h valid=%b want 4/5555/1",
                     level, word, word_valid);
        end
    endtask

    task automatic test_async_reset();
        fetch_en = 1'b1;
        run_to_phase(0);
        tick();
        total++;
        if (ram_oe !== 1'b1 || ram_addr !== 24'h008008) begin
            bad++;
            $display("FAIL areset_issue: got oe=%b addr=%h want 1/008008", ram_oe, ram_addr);
        end
        tick();
        tick();
        #2;
        reset = 1'b1;
        #1;
        total++;
        if (ram_oe !== 1'b0 || level !== 6'd0) begin
            bad++;
            $display("FAIL areset_immediate: got oe=%b level=%0d want 0/0", ram_oe, level);
        end
        fetch_en = 1'b0;
        tick();
        reset = 1'b0;
        tick();
    endtask

`ifdef VIDEO_FETCH_WRAP_EN
    task automatic test_wrap();
        logic [23:0] exp_a [4];
        exp_a[0] = 24'h000100; exp_a[1] = 24'h000104;
        exp_a[2] = 24'h000100; exp_a[3] = 24'h000104;
        start_addr = 24'h000100;
        end_addr   = 24'h000108;
        fetch_en   = 1'b1;
        load = 1'b1;
        tick();
        load = 1'b0;
        run_to_phase(0);
        for (int i = 0; i < 4; i++) begin
            tick();
            total++;
            if (ram_addr !== exp_a[i]) begin
                bad++;
                $display("FAIL wrap_addr%0d: got %h want %h", i, ram_addr, exp_a[i]);
            end
            run_to_phase(0);
        end
        fetch_en = 1'b0;
    endtask
`endif

    initial begin
        test_reset();
        test_fill();
        test_stream();
        test_underrun();
        test_load_discard();
        test_back_to_back();
        test_async_reset();
`ifdef VIDEO_FETCH_WRAP_EN
        test_wrap();
`endif
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
